// File: rtl/ifetch_buf.sv
// ifetch_buf: instruction fetch address generator and prefetch FIFO.
//
// Drives the instruction RAM fetch port (pc_n_o / iram_rd_o), captures the
// word the RAM returns one cycle after each issue into a small FIFO, and
// presents the FIFO head to decode with a valid/ready handshake. A redirect
// (jump_i) flushes buffered and in-flight fetches and issues the target in
// the same cycle.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   pc_n_o       fetch address to the instruction RAM
//   iram_rd_o    fetch read enable (data returns on inst_i next cycle)
//   inst_i       instruction word from the RAM
//   jump_i       redirect request
//   jump_addr_i  redirect target
//   id_valid_o   head entry valid
//   id_ready_i   decode accepts head entry
//   id_inst_o    head instruction
//   id_pc_o      head PC
//   id_err_o     head entry came from a misaligned redirect
//
// Optional feature macro: IFETCH_MISALIGN_EN
//   defined   - misaligned redirect targets are fetched word-aligned and the
//               resulting entry is tagged with id_err_o=1
//   undefined - target low bits are silently dropped, id_err_o tied 0

module ifetch_buf #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc_n_o,
    output logic        iram_rd_o,
    input  logic [31:0] inst_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_inst_o,
    output logic [31:0] id_pc_o,
    output logic        id_err_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    // One extra bit so count + inflight never overflows before the compare.
    localparam int unsigned OW = CW + 1;

    typedef enum logic {
        BOOT,
        RUN
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      boot_cnt_q, boot_cnt_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     inst_mem_q [FIFO_DEPTH];
    logic [31:0]     inst_mem_d [FIFO_DEPTH];
    logic [31:0]     pc_mem_q   [FIFO_DEPTH];
    logic [31:0]     pc_mem_d   [FIFO_DEPTH];

    logic [31:0]     jump_tgt;
    logic            pop;
    logic            push;
    logic            issue;
    logic [OW-1:0]   occ;

    assign jump_tgt = {jump_addr_i[31:2], 2'b00};

`ifdef IFETCH_MISALIGN_EN
    logic            jump_mis;
    logic            req_err_q, req_err_d;
    logic            err_mem_q [FIFO_DEPTH];
    logic            err_mem_d [FIFO_DEPTH];

    assign jump_mis = |jump_addr_i[1:0];
    assign id_err_o = err_mem_q[rptr_q];
`else
    logic            unused_jump_lsb;

    assign unused_jump_lsb = ^jump_addr_i[1:0];
    assign id_err_o        = 1'b0;
`endif

    assign id_inst_o = inst_mem_q[rptr_q];
    assign id_pc_o   = pc_mem_q[rptr_q];

    // Fetch control and decode handshake
    always_comb begin
        id_valid_o = (count_q != '0) & ~jump_i;
        pop        = id_valid_o & id_ready_i;
        pc_n_o     = jump_i ? jump_tgt : fetch_pc_q;
        // Occupancy after this cycle's pop, counting the fetch whose data
        // arrives now; a new issue must still find a free slot for itself.
        occ        = OW'(count_q) + OW'(inflight_q) - OW'(pop);
        issue      = jump_i | ((state_q == RUN) && (occ < OW'(FIFO_DEPTH)));
        iram_rd_o  = issue;
        push       = inflight_q & ~jump_i;
    end

    // Boot sequencing
    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        unique case (state_q)
            BOOT: begin
                if (boot_cnt_q == 2'd2) begin
                    state_d = RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q + 2'd1;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Fetch address and in-flight request tracking
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = issue;
`ifdef IFETCH_MISALIGN_EN
        req_err_d  = req_err_q;
`endif
        if (issue) begin
            req_pc_d   = pc_n_o;
            fetch_pc_d = pc_n_o + 32'd4;
`ifdef IFETCH_MISALIGN_EN
            req_err_d  = jump_i & jump_mis;
`endif
        end
    end

    // Prefetch FIFO
    always_comb begin
        rptr_d     = rptr_q;
        wptr_d     = wptr_q;
        count_d    = count_q;
        inst_mem_d = inst_mem_q;
        pc_mem_d   = pc_mem_q;
`ifdef IFETCH_MISALIGN_EN
        err_mem_d  = err_mem_q;
`endif
        if (jump_i) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                inst_mem_d[wptr_q] = inst_i;
                pc_mem_d[wptr_q]   = req_pc_q;
`ifdef IFETCH_MISALIGN_EN
                err_mem_d[wptr_q]  = req_err_q;
`endif
                wptr_d = wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            boot_cnt_q <= '0;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            inst_mem_q <= '{default: '0};
            pc_mem_q   <= '{default: '0};
`ifdef IFETCH_MISALIGN_EN
            req_err_q  <= 1'b0;
            err_mem_q  <= '{default: 1'b0};
`endif
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            inst_mem_q <= inst_mem_d;
            pc_mem_q   <= pc_mem_d;
`ifdef IFETCH_MISALIGN_EN
            req_err_q  <= req_err_d;
            err_mem_q  <= err_mem_d;
`endif
        end
    end

endmodule
